// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_loader_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 2048;
    localparam int WORD_BYTES          = 4;
    localparam int COUNT_W             = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Word index to byte address: index << 2, zero-extended to 32 bits.
    function automatic logic [31:0] word_byte_addr(input logic [COUNT_W-1:0] idx);
        return {{(32-COUNT_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words.
// Latency: word visible the cycle after the 4th byte; word_full pulses with the 4th byte.
// Backpressure: none here; the caller gates byte_en with its own ready.
module word_assembler
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [31:0] shift_q;
    logic [1:0]  byte_cnt_q;

    // Shift each byte in from the bottom so the first byte ends up in [31:24].
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (clear) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (byte_en) begin
            shift_q    <= {shift_q[23:0], byte_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end
    end

    assign word      = shift_q;
    assign word_full = byte_en && (byte_cnt_q == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into instruction memory as 32-bit words, holding the CPU meanwhile.
// Latency: 4 byte cycles + 1 write cycle per word (one word per 5 cycles at best).
// Backpressure: ByteReady high only in LOAD; ByteValid gaps simply stall the load.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
)(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [COUNT_W-1:0] WordCount,
    input  logic               ByteValid,
    input  logic [7:0]         ByteData,
    output logic               ByteReady,
    output logic               MemWrite,
    output logic [31:0]        MemAddress,
    output logic [31:0]        MemWriteData,
    output logic               CpuHold,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [31:0]        Checksum
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    state_t             state_q, state_nxt;
    logic [COUNT_W-1:0] word_idx_q;
    logic [COUNT_W-1:0] word_cnt_q;
    logic [31:0]        checksum_q;
    logic               error_q;
    logic [31:0]        last_addr_q;
    logic [31:0]        last_data_q;

    logic               start_ok;
    logic               wc_zero;
    logic               wc_over;
    logic               byte_xfer;
    logic               last_word;
    logic [31:0]        asm_word;
    logic               asm_full;

    assign start_ok  = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign wc_zero   = (WordCount == '0);
    assign wc_over   = ({{(32-COUNT_W){1'b0}}, WordCount} > DEPTH_U);
    assign byte_xfer = ByteValid && (state_q == ST_LOAD);
    assign last_word = ((word_idx_q + 1'b1) == word_cnt_q);

    word_assembler u_asm (
        .clk       (Clk),
        .reset     (Reset),
        .clear     (start_ok),
        .byte_en   (byte_xfer),
        .byte_data (ByteData),
        .word      (asm_word),
        .word_full (asm_full)
    );

    // State register; reset discards any in-progress load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: Start only honoured from IDLE/DONE.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    if (wc_over) begin
                        state_nxt = ST_IDLE;
                    end else if (wc_zero) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (asm_full) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_nxt = last_word ? ST_DONE : ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counters, checksum, error flag and the held memory-port values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            word_idx_q  <= '0;
            word_cnt_q  <= '0;
            checksum_q  <= '0;
            error_q     <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            if (start_ok) begin
                if (wc_over) begin
                    error_q <= 1'b1;
                end else begin
                    error_q    <= 1'b0;
                    word_idx_q <= '0;
                    word_cnt_q <= WordCount;
                    checksum_q <= '0;
                end
            end
            if (state_q == ST_WRITE) begin
                checksum_q  <= checksum_q + asm_word;
                word_idx_q  <= word_idx_q + 1'b1;
                last_addr_q <= word_byte_addr(word_idx_q);
                last_data_q <= asm_word;
            end
        end
    end

    assign ByteReady    = (state_q == ST_LOAD);
    assign MemWrite     = (state_q == ST_WRITE);
    assign MemAddress   = MemWrite ? word_byte_addr(word_idx_q) : last_addr_q;
    assign MemWriteData = MemWrite ? asm_word : last_data_q;
    assign Busy         = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign CpuHold      = Busy;
    assign Done         = (state_q == ST_DONE);
    assign Error        = error_q;
    assign Checksum     = checksum_q;

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 2048, SHALL be the number of 32-bit words in the target instruction memory.
REQ-002 Clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-003 Reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 Start  input  1  SHALL be a one-cycle request to begin a load.
REQ-005 WordCount  input  12  SHALL be the number of words to load, sampled when Start is accepted.
REQ-006 ByteValid  input  1  SHALL mark ByteData as valid.
REQ-007 ByteData  input  8  SHALL carry one program byte, most-significant byte of each word first.
REQ-008 ByteReady  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-009 MemWrite  output  1  SHALL be the instruction-memory write enable.
REQ-010 MemAddress  output  32  SHALL be the byte address of the word being written (word index << 2, bits 1:0 = 0).
REQ-011 MemWriteData  output  32  SHALL be the assembled instruction word.
REQ-012 CpuHold  output  1  SHALL hold the processor (PC and fetch) while a load is in progress.
REQ-013 Busy  output  1  SHALL be high in LOAD and WRITE states.
REQ-014 Done  output  1  SHALL be high in DONE state.
REQ-015 Error  output  1  SHALL flag a rejected request (WordCount > DEPTH_WORDS).
REQ-016 Checksum  output  32  SHALL be the modulo-2^32 sum of all words written in the current/last load.

Function
REQ-017 States SHALL be IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE/DONE: Start with 0 < WordCount <= DEPTH_WORDS SHALL enter LOAD next cycle, clearing word index, byte index, Checksum, Error.
REQ-019 IDLE/DONE: Start with WordCount = 0 SHALL enter DONE next cycle with Checksum = 0, no MemWrite.
REQ-020 IDLE/DONE: Start with WordCount > DEPTH_WORDS SHALL enter IDLE with Error = 1; Error stays set until the next accepted Start.
REQ-021 Start SHALL be ignored in LOAD and WRITE.
REQ-022 ByteReady SHALL be 1 only in LOAD; a byte transfers on a cycle with ByteValid && ByteReady.
REQ-023 Transfers SHALL shift into the word big-endian: 1st byte -> [31:24], 4th -> [7:0].
REQ-024 The 4th transfer of a word SHALL move LOAD -> WRITE next cycle.
REQ-025 WRITE SHALL last exactly one cycle with MemWrite = 1, MemAddress = index*4, MemWriteData = assembled word; Checksum updates with that word in the same edge.
REQ-026 After WRITE, index increments; if new index == WordCount, go DONE, else LOAD.
REQ-027 Throughput SHALL be at most one word per 5 cycles; ByteValid gaps stall without loss.
REQ-028 MemWrite SHALL be 0 in every state except WRITE; MemAddress/MemWriteData SHALL hold their last values outside WRITE.
REQ-029 CpuHold SHALL equal Busy; processor released the cycle DONE is entered.
REQ-030 Done SHALL remain 1 until a Start is accepted or Reset asserts.

Reset
REQ-031 Reset SHALL force IDLE, byte/word index 0, and all outputs 0, overriding any in-progress load (partial word discarded, no MemWrite that cycle).
REQ-032 Reset SHALL take priority over Start and ByteValid in the same cycle.

Structure
REQ-033 A shared package SHALL hold the state enum, DEPTH_WORDS default, and WORD_BYTES = 4 constant.
REQ-034 Byte-to-word packing SHALL be a sub-module word_assembler (shift register + 2-bit byte counter, word_full pulse); FSM and counters stay in instruction_loader.

Verification
REQ-035 Start, WordCount=1, bytes 8C,01,00,04 -> one MemWrite, MemAddress=0x0, MemWriteData=0x8C010004, Checksum=0x8C010004, Done=1.
REQ-036 WordCount=3, words 0x00000001/0x00000002/0xFFFFFFFF -> MemAddress 0x0,0x4,0x8 in order, Checksum=0x00000002 (wrap), CpuHold low only after 3rd write.
REQ-037 WordCount=2 with ByteValid toggling every other cycle -> same data as gap-free run, no extra/missing writes.
REQ-038 Start with WordCount=2049 -> Error=1, state IDLE, no MemWrite, ByteReady=0; then valid Start clears Error.
REQ-039 Reset asserted after 2 bytes of word 0 -> outputs 0 next cycle, no MemWrite; a subsequent load of 1 word writes address 0x0 correctly.
REQ-040 Start pulsed during LOAD and WordCount=0 from IDLE -> first ignored; second gives Done next cycle with no MemWrite.
